// File: rtl/hermes_local_injector.sv
// Hermes LOCAL-port packet injector: sends header, size and payload flits from a PE
// into the router under credit-based flow control.
module hermes_local_injector #(
  parameter int unsigned FLIT_SIZE = 32,
  parameter int unsigned ADDR_W    = FLIT_SIZE / 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [ADDR_W-1:0]    req_x_i,
  input  logic [ADDR_W-1:0]    req_y_i,
  input  logic [FLIT_SIZE-1:0] req_size_i,
  input  logic                 pl_valid_i,
  output logic                 pl_ready_o,
  input  logic [FLIT_SIZE-1:0] pl_data_i,
  output logic                 tx_o,
  output logic [FLIT_SIZE-1:0] data_o,
  input  logic                 credit_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [15:0]          pkt_count_o
);

  localparam int unsigned HalfW = FLIT_SIZE / 2;
  localparam int unsigned XW    = HalfW - ADDR_W;

  typedef enum logic [1:0] {StIdle, StHeader, StSize, StPayload} state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    x_q, x_d, y_q, y_d;
  logic [FLIT_SIZE-1:0] size_q, size_d;
  logic [FLIT_SIZE-1:0] rem_q, rem_d;
  logic                 done_q, done_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [FLIT_SIZE-1:0] header;

  always_comb begin
    header             = '0;
    header[HalfW-1:ADDR_W] = XW'(x_q);
    header[ADDR_W-1:0] = y_q;
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    size_d     = size_q;
    rem_d      = rem_q;
    done_d     = 1'b0;
    tx_o       = 1'b0;
    data_o     = '0;
    pl_ready_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          x_d     = req_x_i;
          y_d     = req_y_i;
          size_d  = req_size_i;
          state_d = StHeader;
        end
      end
      StHeader: begin
        tx_o   = 1'b1;
        data_o = header;
        if (credit_i) state_d = StSize;
      end
      StSize: begin
        tx_o   = 1'b1;
        data_o = size_q;
        if (credit_i) begin
          if (size_q == '0) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            rem_d   = size_q;
            state_d = StPayload;
          end
        end
      end
      StPayload: begin
        // Payload is a combinational pass-through; the source sees router credit directly.
        tx_o       = pl_valid_i;
        data_o     = pl_data_i;
        pl_ready_o = credit_i;
        if (pl_valid_i && credit_i) begin
          rem_d = rem_q - FLIT_SIZE'(1);
          if (rem_q == FLIT_SIZE'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    cnt_d = done_d ? cnt_q + 16'd1 : cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      size_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      size_q  <= size_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign busy_o      = (state_q != StIdle);
  assign done_o      = done_q;
  assign pkt_count_o = cnt_q;

endmodule

// File: tb/tb_hermes_local_injector.sv
// Directed bench for hermes_local_injector: flit order, stalls, gaps, reset and count wrap.
module tb_hermes_local_injector;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [7:0]  req_x_i = '0;
  logic [7:0]  req_y_i = '0;
  logic [31:0] req_size_i = '0;
  logic        pl_valid_i = 1'b0;
  logic        pl_ready_o;
  logic [31:0] pl_data_i = '0;
  logic        tx_o;
  logic [31:0] data_o;
  logic        credit_i = 1'b1;
  logic        busy_o;
  logic        done_o;
  logic [15:0] pkt_count_o;

  hermes_local_injector #(.FLIT_SIZE(32), .ADDR_W(8)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_x_i     (req_x_i),
    .req_y_i     (req_y_i),
    .req_size_i  (req_size_i),
    .pl_valid_i  (pl_valid_i),
    .pl_ready_o  (pl_ready_o),
    .pl_data_i   (pl_data_i),
    .tx_o        (tx_o),
    .data_o      (data_o),
    .credit_i    (credit_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .pkt_count_o (pkt_count_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] got[$];
  int          done_cnt = 0;
  bit          plr_seen = 1'b0;
  logic [15:0] exp_cnt = '0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Called at negedge+1: inputs are stable until the next negedge, so a transfer seen here happens.
  task automatic sample_and_wait();
    if (tx_o && credit_i) got.push_back(data_o);
    if (done_o) done_cnt++;
    if (pl_ready_o) plr_seen = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic run_pkt(input logic [7:0] x, input logic [7:0] y, input logic [31:0] size,
                         input logic [31:0] base, input int cmode, input int vmode,
                         input int abort_at);
    int   cyc = 0;
    int   idx = 0;
    int   sc = 0;
    int   ntx;
    int   n = int'(size) + 2;
    bit   fin = 1'b0;
    bit   stall = 1'b0;
    bit   take;
    logic [31:0] sdata = '0;
    logic [31:0] exp;
    got.delete();
    done_cnt = 0;
    plr_seen = 1'b0;
    credit_i = 1'b1;
    pl_valid_i = 1'b0;
    req_valid_i = 1'b1;
    req_x_i = x;
    req_y_i = y;
    req_size_i = size;
    #1;
    n_checks++;
    if (req_ready_o !== 1'b1) $display("FAIL req_ready_idle: got %b want 1", req_ready_o);
    else n_pass++;
    sample_and_wait();
    req_valid_i = 1'b0;
    while (!fin && cyc < 300) begin
      ntx = got.size();
      if (cmode == 1 && ntx == 1) begin
        credit_i = (sc >= 4);
        sc++;
      end else if (cmode == 1 && ntx >= 2) begin
        credit_i = (cyc % 2 == 1);
      end else begin
        credit_i = 1'b1;
      end
      if (vmode == 0 || stall) pl_valid_i = 1'b1;
      else pl_valid_i = (cyc % 2 == 0);
      pl_data_i = base + idx;
      #1;
      if (stall) begin
        n_checks++;
        if (tx_o !== 1'b1 || data_o !== sdata)
          $display("FAIL stall_hold: got tx=%b data=%h want tx=1 data=%h", tx_o, data_o, sdata);
        else n_pass++;
      end
      if (vmode == 1 && ntx >= 2 && ntx < n) begin
        n_checks++;
        if (tx_o !== pl_valid_i)
          $display("FAIL tx_follows_valid: got %b want %b", tx_o, pl_valid_i);
        else n_pass++;
      end
      stall = tx_o && !credit_i;
      sdata = data_o;
      take = pl_valid_i && pl_ready_o;
      sample_and_wait();
      if (take) idx++;
      cyc++;
      if (done_cnt > 0 || (abort_at >= 0 && got.size() == abort_at)) fin = 1'b1;
    end
    if (!fin) begin
      n_checks++;
      $display("FAIL pkt_timeout: got %0d flits want completion", got.size());
    end else if (abort_at < 0) begin
      n_checks++;
      if (got.size() != n) $display("FAIL flit_count: got %0d want %0d", got.size(), n);
      else begin
        n_pass++;
        for (int i = 0; i < n; i++) begin
          if (i == 0) exp = {16'h0, x, y};
          else if (i == 1) exp = size;
          else exp = base + 32'(i - 2);
          n_checks++;
          if (got[i] !== exp) $display("FAIL flit[%0d]: got %h want %h", i, got[i], exp);
          else n_pass++;
        end
      end
      n_checks++;
      if (done_cnt != 1) $display("FAIL done_pulses: got %0d want 1", done_cnt);
      else n_pass++;
      exp_cnt = exp_cnt + 16'd1;
      n_checks++;
      if (pkt_count_o !== exp_cnt) $display("FAIL pkt_count: got %h want %h", pkt_count_o, exp_cnt);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    credit_i = 1'b1;
    pl_valid_i = 1'b1;
    req_valid_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    n_checks++;
    if ({tx_o, req_ready_o, pl_ready_o, busy_o, done_o} !== 5'b01000)
      $display("FAIL reset_ctrl: got tx,rdy,plr,busy,done=%b want 01000",
               {tx_o, req_ready_o, pl_ready_o, busy_o, done_o});
    else n_pass++;
    n_checks++;
    if (pkt_count_o !== 16'h0) $display("FAIL reset_count: got %h want 0000", pkt_count_o);
    else n_pass++;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    pl_valid_i = 1'b0;
    rst_ni = 1'b1;
    exp_cnt = '0;
    @(negedge clk_i);
  endtask

  task automatic test_basic();
    run_pkt(8'd2, 8'd3, 32'd3, 32'hA1, 0, 0, -1);
  endtask

  task automatic test_stall();
    run_pkt(8'd2, 8'd3, 32'd3, 32'hA1, 1, 0, -1);
  endtask

  task automatic test_size_zero();
    run_pkt(8'd1, 8'd0, 32'd0, 32'h0, 0, 0, -1);
    n_checks++;
    if (plr_seen !== 1'b0) $display("FAIL size0_pl_ready: got %b want 0", plr_seen);
    else n_pass++;
  endtask

  task automatic test_gaps();
    run_pkt(8'd4, 8'd5, 32'd4, 32'hB0, 0, 1, -1);
  endtask

  task automatic test_reset_mid();
    run_pkt(8'd6, 8'd7, 32'd5, 32'hC0, 0, 0, 4);
    n_checks++;
    if (busy_o !== 1'b1 || tx_o !== 1'b1)
      $display("FAIL mid_busy: got busy=%b tx=%b want 1 1", busy_o, tx_o);
    else n_pass++;
    #2 rst_ni = 1'b0;
    #1;
    n_checks++;
    if ({tx_o, busy_o, pl_ready_o, req_ready_o} !== 4'b0001 || pkt_count_o !== 16'h0)
      $display("FAIL async_reset: got tx,busy,plr,rdy=%b cnt=%h want 0001 0000",
               {tx_o, busy_o, pl_ready_o, req_ready_o}, pkt_count_o);
    else n_pass++;
    exp_cnt = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    run_pkt(8'd6, 8'd7, 32'd5, 32'hC0, 0, 0, -1);
  endtask

  task automatic test_back_to_back();
    logic [7:0]  txv = '0;
    logic [7:0]  rdy = '0;
    logic [7:0]  dn = '0;
    logic [31:0] exp[6];
    bit          take;
    rst_ni = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    got.delete();
    done_cnt = 0;
    credit_i = 1'b1;
    pl_valid_i = 1'b1;
    pl_data_i = 32'hD0;
    req_valid_i = 1'b1;
    req_x_i = 8'd1;
    req_y_i = 8'd1;
    req_size_i = 32'd1;
    #1;
    sample_and_wait();
    req_x_i = 8'd2;
    req_y_i = 8'd2;
    for (int k = 0; k < 8; k++) begin
      #1;
      txv[k] = tx_o;
      rdy[k] = req_ready_o;
      dn[k] = done_o;
      take = pl_valid_i && pl_ready_o;
      sample_and_wait();
      if (take) pl_data_i = pl_data_i + 32'd1;
      if (k == 3) req_valid_i = 1'b0;
    end
    n_checks++;
    if (txv !== 8'b0111_0111) $display("FAIL b2b_tx: got %b want 01110111", txv);
    else n_pass++;
    n_checks++;
    if (rdy !== 8'b1000_1000) $display("FAIL b2b_ready: got %b want 10001000", rdy);
    else n_pass++;
    n_checks++;
    if (dn !== 8'b1000_1000) $display("FAIL b2b_done: got %b want 10001000", dn);
    else n_pass++;
    exp = '{32'h0101, 32'h1, 32'hD0, 32'h0202, 32'h1, 32'hD1};
    n_checks++;
    if (got.size() != 6) $display("FAIL b2b_flits: got %0d want 6", got.size());
    else begin
      n_pass++;
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (got[i] !== exp[i]) $display("FAIL b2b_flit[%0d]: got %h want %h", i, got[i], exp[i]);
        else n_pass++;
      end
    end
    n_checks++;
    if (pkt_count_o !== 16'd2) $display("FAIL b2b_count: got %h want 0002", pkt_count_o);
    else n_pass++;
    exp_cnt = 16'd2;
  endtask

  task automatic test_wrap();
    // Stand-in for 65534 earlier size-0 packets.
    force dut.cnt_q = 16'hFFFE;
    @(negedge clk_i);
    release dut.cnt_q;
    @(negedge clk_i);
    exp_cnt = 16'hFFFE;
    n_checks++;
    if (pkt_count_o !== 16'hFFFE) $display("FAIL wrap_preload: got %h want fffe", pkt_count_o);
    else n_pass++;
    run_pkt(8'd3, 8'd1, 32'd0, 32'h0, 0, 0, -1);
    run_pkt(8'd3, 8'd1, 32'd0, 32'h0, 0, 0, -1);
    n_checks++;
    if (pkt_count_o !== 16'h0000) $display("FAIL wrap_zero: got %h want 0000", pkt_count_o);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_size_zero();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hermes_local_injector.md
Name: hermes_local_injector

Overview:
- Packet transmitter for a Hermes router LOCAL input port.
- Accepts a packet descriptor (target XY, payload length) and a payload flit stream from the IP/PE side.
- Emits header flit, size flit, then payload flits under the router's credit-based flow control.
- Pairs with the router's local output/ejection path; one instance per tile, between the PE and router port HERMES_LOCAL.

Parameters:
- FLIT_SIZE, 32, flit width in bits; must be even and ≥16.
- ADDR_W, FLIT_SIZE/4, width of each X and Y coordinate field.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  descriptor valid.
- req_ready_o  out  1  descriptor accepted when valid&&ready.
- req_x_i  in  ADDR_W  target X coordinate.
- req_y_i  in  ADDR_W  target Y coordinate.
- req_size_i  in  FLIT_SIZE  payload flit count; 0 is legal.
- pl_valid_i  in  1  payload flit valid.
- pl_ready_o  out  1  payload flit consumed when valid&&ready.
- pl_data_i  in  FLIT_SIZE  payload flit.
- tx_o  out  1  flit valid toward router local input.
- data_o  out  FLIT_SIZE  flit toward router.
- credit_i  in  1  router buffer can accept a flit this cycle.
- busy_o  out  1  packet in progress (state != IDLE).
- done_o  out  1  one-cycle pulse after the last flit of a packet transfers.
- pkt_count_o  out  16  count of completed packets; wraps 0xFFFF->0.

Behaviour:
- Transfer rule: a flit moves on any rising edge with tx_o && credit_i. While tx_o=1 and credit_i=0, data_o is held stable and tx_o stays 1. tx_o is never withdrawn before transfer.
- Reset (rst_ni=0, any time, including mid-packet):
  - FSM returns to IDLE.
  - tx_o=0, req_ready_o=1, pl_ready_o=0, busy_o=0, done_o=0, pkt_count_o=0.
  - Captured descriptor and remaining-flit counter are cleared.
  - A partially sent packet is abandoned; no recovery is attempted.
- FSM states:
  - IDLE:
    - req_ready_o=1, tx_o=0.
    - On req_valid_i, capture x, y and size into registers, then go to HEADER.
  - HEADER:
    - tx_o=1.
    - data_o = {upper FLIT_SIZE/2 bits zero, X in [FLIT_SIZE/2-1:ADDR_W], Y in [ADDR_W-1:0]}.
    - On transfer, go to SIZE.
  - SIZE:
    - tx_o=1, data_o = captured size.
    - On transfer: if size==0, go to IDLE and pulse done; otherwise load remaining=size and go to PAYLOAD.
  - PAYLOAD:
    - tx_o = pl_valid_i; data_o = pl_data_i; pl_ready_o = credit_i. The payload path is combinational pass-through.
    - On each transfer, remaining decrements.
    - On the transfer with remaining==1, go to IDLE and pulse done.
- pl_ready_o is 0 in every state other than PAYLOAD. Payload presented early is not consumed.
- done_o is registered: high for exactly the cycle after the final flit transfers. pkt_count_o increments on that same edge.
- req_ready_o is 0 outside IDLE. A new descriptor is accepted at the earliest one cycle after returning to IDLE, so back-to-back packets have a 1-cycle bubble.
- Latency: the header is on data_o in the cycle after descriptor acceptance. With credit_i held high, a packet of N payload flits occupies N+2 consecutive transfer cycles.
- The remaining counter is FLIT_SIZE wide, so no overflow is possible. Size 0xFFFF_FFFF must be supported without wrap.
- When data_o is not a valid flit (tx_o=0), its value is don't-care. The bench must not check it.

Test Plan:
- Reset, then descriptor x=2, y=3, size=3 with credit_i=1 and payload 0xA1, 0xA2, 0xA3 always valid:
  - data_o sequence 0x00000203, 0x00000003, 0xA1, 0xA2, 0xA3 on 5 consecutive transfer cycles.
  - done_o pulses once; pkt_count_o=1.
- Same packet with credit_i low for 4 cycles during the SIZE flit and every other cycle during payload:
  - data_o and tx_o stay stable while stalled.
  - Exactly 5 transfers occur, with no duplication or loss.
- size=0 to x=1, y=0:
  - Only 0x00000100 and 0x00000000 are sent; pl_ready_o is never asserted.
  - done_o pulses after the second flit.
- Payload source gaps (pl_valid_i toggling) with credit_i=1:
  - tx_o follows pl_valid_i; no transfer occurs while pl_valid_i=0; the 4-flit packet completes in order.
- Reset asserted mid-PAYLOAD (2 of 5 flits sent):
  - tx_o, busy_o and pkt_count_o go to 0 immediately (asynchronously).
  - A new descriptor after release produces a correct, complete packet.
- Two descriptors presented back-to-back:
  - The second is accepted only in IDLE, after the first packet's done_o.
  - pkt_count_o=2; wrap check: preload by 65536 packets of size 0 gives pkt_count_o=0.
